// File: rtl/ak4619_pkg.sv
// Shared AK4619 codec interface definitions.
// Used by both the TDM receive and transmit paths.
package ak4619_pkg;

   localparam int AK_W           = 16;
   localparam int AK_N_CH        = 4;
   localparam int AK_FRAME_BICKS = AK_W * AK_N_CH;
   localparam int AK_CNT_W       = $clog2(AK_FRAME_BICKS);

   typedef enum logic {
      SEEK = 1'b0,
      RUN  = 1'b1
   } rx_state_t;

endpackage

// File: rtl/ak4619_edge_sync.sv
// Two-flop synchronizer with rising-edge detect.
// rise is high for one clk after the input goes 0->1.
module ak4619_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);

   logic q;
   logic q2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q  <= 1'b0;
         q2 <= 1'b0;
      end else begin
         q  <= sig;
         q2 <= q;
      end
   end

   assign rise = q & ~q2;

endmodule

// File: rtl/ak4619_tdm_rx.sv
// AK4619 ADC TDM deserializer: N_CH slots of W bits per lrck frame,
// published together with a one-cycle strobe.
module ak4619_tdm_rx
   import ak4619_pkg::*;
#(
   parameter int W           = AK_W,
   parameter int N_CH        = AK_N_CH,
   parameter int FRAME_BICKS = AK_FRAME_BICKS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                bick,
   input  logic                lrck,
   input  logic                sdout1,
   output logic signed [W-1:0] sample0,
   output logic signed [W-1:0] sample1,
   output logic signed [W-1:0] sample2,
   output logic signed [W-1:0] sample3,
   output logic                sample_valid,
   output logic                frame_err,
   output logic                locked
);

   localparam int CW = $clog2(FRAME_BICKS);
   localparam int SW = $clog2(W);

   logic             bick_rise;
   logic             lrck_rise;
   logic             sdout1_q;
   rx_state_t        state;
   logic [CW-1:0]    cnt;
   logic             wrapped;
   logic [W-1:0]     shreg;
   logic [W-1:0]     sh_nx;
   logic [W-1:0]     sh_first;
   logic [W-1:0]     hold [N_CH-1];
   logic [CW-SW-1:0] slot;
   logic             slot_end;
   logic             last;

   ak4619_edge_sync u_bick (
      .clk  (clk),
      .rst_n(rst_n),
      .sig  (bick),
      .rise (bick_rise)
   );

   ak4619_edge_sync u_lrck (
      .clk  (clk),
      .rst_n(rst_n),
      .sig  (lrck),
      .rise (lrck_rise)
   );

   // Data is registered once so it lines up with bick_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sdout1_q <= 1'b0;
      else        sdout1_q <= sdout1;
   end

   assign sh_nx    = {shreg[W-2:0], sdout1_q};
   assign sh_first = {{(W-1){1'b0}}, sdout1_q};
   assign slot     = cnt[CW-1:SW];
   assign slot_end = &cnt[SW-1:0];
   assign last     = &cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= SEEK;
         cnt          <= '0;
         wrapped      <= 1'b0;
         shreg        <= '0;
         for (int i = 0; i < N_CH-1; i++) hold[i] <= '0;
         sample0      <= '0;
         sample1      <= '0;
         sample2      <= '0;
         sample3      <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         locked       <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         // Frame start wins; a coincident bick is shifted as bit 0.
         if (lrck_rise) begin
            state     <= RUN;
            locked    <= 1'b1;
            frame_err <= (state == RUN) && (cnt != '0);
            wrapped   <= 1'b0;
            cnt       <= bick_rise ? CW'(1) : '0;
            shreg     <= bick_rise ? sh_first : '0;
         end else if (state == RUN && bick_rise) begin
            if (last && wrapped) begin
               frame_err <= 1'b1;
               locked    <= 1'b0;
               state     <= SEEK;
               cnt       <= '0;
            end else begin
               shreg <= sh_nx;
               cnt   <= cnt + 1'b1;
               if (slot_end && !last) hold[slot] <= sh_nx;
               if (last) begin
                  wrapped      <= 1'b1;
                  sample0      <= hold[0];
                  sample1      <= hold[1];
                  sample2      <= hold[2];
                  sample3      <= sh_nx;
                  sample_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule
